// File: rtl/fp_sqr_arbiter.sv
// fp_sqr_arbiter: round-robin sharing of one fp_sqr unit among requesters.
// Operand is held on the unit until done, result goes back to its owner.
module fp_sqr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_data,
  input  logic [N_REQ*3-1:0] req_round,
  output logic [N_REQ-1:0]   resp_valid,
  input  logic [N_REQ-1:0]   resp_ready,
  output logic [W-1:0]       resp_data,
  output logic [4:0]         resp_flags,
  output logic [W-1:0]       sq_in,
  output logic [2:0]         sq_round,
  output logic               sq_act,
  input  logic [W-1:0]       sq_out,
  input  logic               sq_ov,
  input  logic               sq_un,
  input  logic               sq_inv,
  input  logic               sq_inexact,
  input  logic               sq_done,
  output logic               busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] QNAN = W'(32'h7FC0_0000);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] rr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] pick;
  logic [IW-1:0] jc;
  logic          hit;
  logic [CW-1:0] cnt;
  int            j;

  // First pending requester at or after rr, wrapping.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    j    = 0;
    jc   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jc = IW'(j);
      if (!hit && req_valid[jc]) begin
        hit  = 1'b1;
        pick = jc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rr         <= '0;
      gidx       <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_flags <= '0;
      sq_in      <= '0;
      sq_round   <= '0;
      sq_act     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      req_ready <= '0;
      unique case (state)
        S_IDLE: begin
          if (hit) begin
            req_ready[pick] <= 1'b1;
            sq_in    <= req_data[pick*W +: W];
            sq_round <= req_round[pick*3 +: 3];
            gidx     <= pick;
            sq_act   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Early done pulses may belong to the previous operation.
          if (cnt >= CW'(SETTLE) && sq_done) begin
            resp_data  <= sq_out;
            resp_flags <= {sq_ov, sq_un, sq_inv,
                           sq_inexact, 1'b0};
            resp_valid[gidx] <= 1'b1;
            sq_act <= 1'b0;
            state  <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            resp_data  <= QNAN;
            resp_flags <= 5'b00101;
            resp_valid[gidx] <= 1'b1;
            sq_act <= 1'b0;
            state  <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready[gidx]) begin
            resp_valid <= '0;
            rr <= (gidx == IW'(N_REQ - 1)) ?
                  '0 : gidx + 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqr_arbiter.sv
// tb_fp_sqr_arbiter: directed bench with a behavioural fp_sqr stub.
// Stub latency and early-done pulses are set per test.
module tb_fp_sqr_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int SETTLE = 2;
  localparam int TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data = '0;
  logic [N*3-1:0] req_round = '0;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready = '0;
  logic [W-1:0]   resp_data;
  logic [4:0]     resp_flags;
  logic [W-1:0]   sq_in;
  logic [2:0]     sq_round;
  logic           sq_act;
  logic [W-1:0]   sq_out;
  logic           sq_ov, sq_un, sq_inv, sq_inexact, sq_done;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int lat_cfg = 3;
  bit early = 1'b0;
  int act_cnt = 0;

  fp_sqr_arbiter #(
    .N_REQ(N), .W(W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_round(req_round),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_flags(resp_flags),
    .sq_in(sq_in), .sq_round(sq_round), .sq_act(sq_act),
    .sq_out(sq_out), .sq_ov(sq_ov), .sq_un(sq_un),
    .sq_inv(sq_inv), .sq_inexact(sq_inexact),
    .sq_done(sq_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub unit: act_cnt is 0 in ISSUE, 1 in the first WAIT cycle.
  always @(posedge clk) act_cnt <= sq_act ? act_cnt + 1 : 0;

  function automatic logic [31:0] model_out(input logic [31:0] x);
    case (x)
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      32'h41800000: return 32'h40800000;
      32'h40000000: return 32'h3FB504F3;
      32'h3F800000: return 32'h3F800000;
      default:      return 32'h7FC00000;
    endcase
  endfunction

  assign sq_out     = model_out(sq_in);
  assign sq_inv     = sq_in[31] & (sq_in[30:0] != '0);
  assign sq_inexact = (sq_in == 32'h40000000);
  assign sq_ov      = 1'b0;
  assign sq_un      = 1'b0;
  assign sq_done    = sq_act &&
    ((early && (act_cnt == 1 || act_cnt == 2)) ||
     (lat_cfg >= 0 && act_cnt >= lat_cfg));

  task automatic drive_req(input int i, input logic [31:0] op,
                           input logic [2:0] rm);
    req_data[i*W +: W] = op;
    req_round[i*3 +: 3] = rm;
    req_valid[i] = 1'b1;
  endtask

  task automatic accept(input int i);
    resp_ready[i] = 1'b1;
    @(negedge clk);
    resp_ready[i] = 1'b0;
  endtask

  task automatic wait_resp(input int k0, output int lat);
    lat = -1;
    for (int c = k0 + 1; c < k0 + 200; c++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL resp_wait got=none want=resp_valid");
    end
  endtask

  // Issue one request and return cycles from ready pulse to resp.
  task automatic run_one(input int i, input logic [31:0] op,
                         input logic [2:0] rm, output int lat);
    bit ok;
    ok = 1'b0;
    lat = -1;
    drive_req(i, op, rm);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid[i] = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL grant_wait req=%0d got=none want=ready", i);
      return;
    end
    wait_resp(0, lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [79:0] all;
    repeat (2) @(negedge clk);
    all = {req_ready, resp_valid, resp_data, resp_flags,
           sq_in, sq_round, sq_act, busy};
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL reset_outs got=%h want=0", all);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, sq_act, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_idle got=%b want=0",
               {busy, sq_act, req_ready});
    end
  endtask

  task automatic test_single();
    int lat;
    drive_req(0, 32'h40800000, 3'd0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant got=%b want=0001", req_ready);
    end
    checks++;
    if ({sq_in, sq_round, sq_act, busy} !==
        {32'h40800000, 3'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_issue got=%h/%0d/%b/%b want=40800000/0/1/1",
               sq_in, sq_round, sq_act, busy);
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_pulse got=%b want=0000", req_ready);
    end
    wait_resp(1, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL single_lat got=%0d want=4", lat);
    end
    checks++;
    if ({resp_valid, resp_data, resp_flags} !==
        {4'b0001, 32'h40000000, 5'b00000}) begin
      errors++;
      $display("FAIL single_resp got=%b/%h/%b want=0001/40000000/00000",
               resp_valid, resp_data, resp_flags);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0001 || sq_act !== 1'b0) begin
      errors++;
      $display("FAIL single_hold got=%b/%b want=0001/0",
               resp_valid, sq_act);
    end
    accept(0);
    checks++;
    if ({resp_valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL single_accept got=%b/%b want=0000/0",
               resp_valid, busy);
    end
  endtask

  task automatic test_settle();
    int lat;
    early = 1'b1;
    lat_cfg = 6;
    run_one(1, 32'h41100000, 3'd1, lat);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL settle_mask_lat got=%0d want=7", lat);
    end
    checks++;
    if (resp_valid !== 4'b0010 || resp_data !== 32'h40400000) begin
      errors++;
      $display("FAIL settle_resp got=%b/%h want=0010/40400000",
               resp_valid, resp_data);
    end
    accept(1);
    early = 1'b0;
    lat_cfg = 2;
    run_one(3, 32'h3F800000, 3'd0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL settle_edge_lat got=%0d want=4", lat);
    end
    accept(3);
    lat_cfg = 3;
  endtask

  task automatic test_round_robin();
    logic [31:0] ops [4];
    logic [31:0] res [4];
    logic [4:0]  flg [4];
    int exp_g [5];
    int ng, nr;
    ops = '{32'h40800000, 32'h41100000,
            32'h41800000, 32'h40000000};
    res = '{32'h40000000, 32'h40400000,
            32'h40800000, 32'h3FB504F3};
    flg = '{5'b00000, 5'b00000, 5'b00000, 5'b00010};
    exp_g = '{0, 1, 2, 3, 0};
    ng = 0;
    nr = 0;
    do_reset();
    for (int i = 0; i < N; i++) drive_req(i, ops[i], 3'(i));
    resp_ready = '1;
    for (int c = 0; c < 100 && nr < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0 && ng < 5) begin
        checks++;
        if (req_ready !== 4'(1 << exp_g[ng]) ||
            sq_in !== ops[exp_g[ng]]) begin
          errors++;
          $display("FAIL rr_grant%0d got=%b/%h want=%b/%h", ng,
                   req_ready, sq_in, 4'(1 << exp_g[ng]),
                   ops[exp_g[ng]]);
        end
        ng++;
      end
      if (resp_valid != '0) begin
        checks++;
        if (resp_valid !== 4'(1 << exp_g[nr]) ||
            resp_data !== res[exp_g[nr]] ||
            resp_flags !== flg[exp_g[nr]]) begin
          errors++;
          $display("FAIL rr_resp%0d got=%b/%h/%b want=%b/%h/%b", nr,
                   resp_valid, resp_data, resp_flags,
                   4'(1 << exp_g[nr]), res[exp_g[nr]],
                   flg[exp_g[nr]]);
        end
        nr++;
        if (nr == 5) req_valid = '0;
      end
    end
    req_valid = '0;
    @(negedge clk);
    resp_ready = '0;
    checks++;
    if (ng !== 5 || nr !== 5) begin
      errors++;
      $display("FAIL rr_count got=%0d/%0d want=5/5", ng, nr);
    end
  endtask

  task automatic test_negative();
    int lat;
    run_one(2, 32'hC0000000, 3'd0, lat);
    checks++;
    if ({resp_valid, resp_data, resp_flags} !==
        {4'b0100, 32'h7FC00000, 5'b00100}) begin
      errors++;
      $display("FAIL neg_resp got=%b/%h/%b want=0100/7fc00000/00100",
               resp_valid, resp_data, resp_flags);
    end
    accept(2);
  endtask

  task automatic test_hold();
    int lat;
    run_one(1, 32'h40800000, 3'd2, lat);
    drive_req(3, 32'h41100000, 3'd0);
    resp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 4'b0010 || resp_data !== 32'h40000000 ||
          resp_flags !== 5'b0 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL hold%0d got=%b/%h/%b/%b want=0010/40000000/0/0000",
                 c, resp_valid, resp_data, resp_flags, req_ready);
      end
    end
    resp_ready = 4'b0010;
    @(negedge clk);
    resp_ready = '0;
    checks++;
    if (resp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL hold_accept got=%b want=0000", resp_valid);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000 || sq_in !== 32'h41100000) begin
      errors++;
      $display("FAIL hold_next got=%b/%h want=1000/41100000",
               req_ready, sq_in);
    end
    req_valid[3] = 1'b0;
    wait_resp(0, lat);
    checks++;
    if (resp_valid !== 4'b1000 || resp_data !== 32'h40400000) begin
      errors++;
      $display("FAIL hold_req3 got=%b/%h want=1000/40400000",
               resp_valid, resp_data);
    end
    accept(3);
  endtask

  task automatic test_timeout();
    int lat;
    lat_cfg = -1;
    run_one(0, 32'h40800000, 3'd0, lat);
    checks++;
    if (lat !== TIMEOUT + 1) begin
      errors++;
      $display("FAIL tmo_lat got=%0d want=%0d", lat, TIMEOUT + 1);
    end
    checks++;
    if ({resp_valid, resp_data, resp_flags} !==
        {4'b0001, 32'h7FC00000, 5'b00101}) begin
      errors++;
      $display("FAIL tmo_resp got=%b/%h/%b want=0001/7fc00000/00101",
               resp_valid, resp_data, resp_flags);
    end
    accept(0);
    lat_cfg = 3;
  endtask

  task automatic test_reset_mid();
    logic [79:0] all;
    int lat;
    bit ok;
    ok = 1'b0;
    lat_cfg = -1;
    drive_req(0, 32'h40800000, 3'd0);
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = req_ready[0];
    end
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sq_act !== 1'b1 || !ok) begin
      errors++;
      $display("FAIL mid_wait got=%b want=1", sq_act);
    end
    rst = 1'b0;
    #1;
    all = {req_ready, resp_valid, resp_data, resp_flags,
           sq_in, sq_round, sq_act, busy};
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL mid_async got=%h want=0", all);
    end
    lat_cfg = 3;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({resp_valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL mid_noresp got=%b/%b want=0000/0",
               resp_valid, busy);
    end
    drive_req(1, 32'h3F800000, 3'd0);
    drive_req(0, 32'h41800000, 3'd0);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_rr got=%b want=0001", req_ready);
    end
    wait_resp(0, lat);
    checks++;
    if (resp_valid !== 4'b0001 || resp_data !== 32'h40800000 ||
        lat !== 4) begin
      errors++;
      $display("FAIL mid_serve got=%b/%h/%0d want=0001/40800000/4",
               resp_valid, resp_data, lat);
    end
    accept(0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle got=%b want=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_settle();
    test_round_robin();
    test_negative();
    test_hold();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_sqr_arbiter.md
Name: fp_sqr_arbiter

Overview:
Shares one fp_sqr square-root unit among N_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block holds the operand and rounding mode stable on the unit for the whole operation.
- It waits for done, captures the result and flags, and returns them to the originating requester only.
- It sits between the FPU command decoder ports and the single fp_sqr instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 32, operand/result width
SETTLE, 2, cycles after issue during which sq_done is ignored (stale-done mask)
TIMEOUT, 64, max cycles in WAIT before abort

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester request accepted (one-hot or zero)
req_data  input  N_REQ*W  operands, requester i at [i*W +: W]
req_round  input  N_REQ*3  rounding modes, requester i at [i*3 +: 3]
resp_valid  output  N_REQ  response valid, one-hot or zero
resp_ready  input  N_REQ  per-requester response accept
resp_data  output  W  result (shared bus, qualified by resp_valid)
resp_flags  output  5  {ov,un,inv,inexact,timeout}
sq_in  output  W  operand to fp_sqr
sq_round  output  3  round_m to fp_sqr
sq_act  output  1  act to fp_sqr, high during ISSUE and WAIT
sq_out  input  W  fp_sqr result
sq_ov, sq_un, sq_inv, sq_inexact, sq_done  input  1 each  fp_sqr flags
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=0): state=IDLE; rr pointer=0; all outputs 0 (req_ready, resp_valid, resp_data, resp_flags, sq_in, sq_round, sq_act, busy). Reset mid-operation abandons it; no response is issued.
- Only registered outputs; req_ready is a one-cycle registered pulse.

FSM states:
- IDLE:
  - If any req_valid, grant the first set bit at or after the rr pointer, wrapping modulo N_REQ.
  - Pulse req_ready[g] for one cycle.
  - Latch req_data[g] into sq_in and req_round[g] into sq_round; store g.
  - Move to ISSUE.
- ISSUE (1 cycle): sq_act=1; cnt=0; move to WAIT.
- WAIT:
  - sq_act=1; cnt increments each cycle.
  - sq_done is ignored while cnt<SETTLE.
  - When cnt>=SETTLE and sq_done=1: capture sq_out into resp_data, capture flags with timeout=0, move to RESP.
  - If cnt reaches TIMEOUT first: resp_data=32'h7FC00000, flags={0,0,1,0,1}, move to RESP.
- RESP:
  - sq_act=0; resp_valid[g]=1. resp_data and resp_flags hold stable until resp_ready[g]=1.
  - On accept: resp_valid=0, rr pointer=g+1 (mod N_REQ), go to IDLE.
  - resp_ready on other indices is ignored.

Other rules:
- sq_in and sq_round hold constant from ISSUE until the next grant.
- A requester must hold req_valid/req_data until its req_ready pulse.
- Deasserting req_valid before grant withdraws the request.
- Minimum turnaround per request: 1 (grant) + 1 (ISSUE) + SETTLE + 1 (capture) + 1 (resp handshake) cycles.
- Max throughput is one operation in flight; no new grant while busy.
- A requester re-requesting immediately after its response gets lower priority than any other pending requester.

Test Plan:
- Single request, req 0, operand 0x40800000 (4.0), round RNe -> req_ready[0] pulse; resp_valid[0] with resp_data=0x40000000, flags=0.
- Reqs 0..3 all valid continuously, resp_ready tied high -> grant order 0,1,2,3,0 and each resp_valid matches the granted index.
- Req 2 operand 0xC0000000 (-2.0) -> resp_data=0x7FC00000, inv=1, timeout=0, delivered on resp_valid[2] only.
- Req 1 with resp_ready[1] held low for 10 cycles while req 3 is valid -> resp held stable, no grant to 3 until the accept, then req 3 is granted.
- sq_done forced low (stub unit) -> after TIMEOUT cycles resp_flags timeout=1, resp_data=0x7FC00000; sq_done high during the SETTLE window is ignored.
- rst pulsed low during WAIT -> all outputs 0 immediately, rr pointer=0, no response; next request is served normally.
